bsg_axil_rw_serializer: RTL and testbench

//  Shares one AXI4-Lite subordinate (m00) between the read and write channels of one manager (s00).
//  At most one transaction (read or write) is in flight at any time; the two directions alternate

---
 rtl/bsg_axil_rw_serializer_if.sv | 47 ++++
 rtl/bsg_axil_rw_serializer.sv | 131 +++++++++++++
 tb/tb_bsg_axil_rw_serializer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_axil_rw_serializer_if.sv
// rtl/bsg_axil_rw_serializer_if.sv - AXI4-Lite bundle with manager/subordinate modports
interface bsg_axil_rw_serializer_if #(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32
);
    localparam int mask_width_lp = data_width_p >> 3;

    logic [addr_width_p-1:0]  awaddr;
    logic [2:0]               awprot;
    logic                     awvalid;
    logic                     awready;

    logic [data_width_p-1:0]  wdata;
    logic [mask_width_lp-1:0] wstrb;
    logic                     wvalid;
    logic                     wready;

    logic [1:0]               bresp;
    logic                     bvalid;
    logic                     bready;

    logic [addr_width_p-1:0]  araddr;
    logic [2:0]               arprot;
    logic                     arvalid;
    logic                     arready;

    logic [data_width_p-1:0]  rdata;
    logic [1:0]               rresp;
    logic                     rvalid;
    logic                     rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/bsg_axil_rw_serializer.sv
// rtl/bsg_axil_rw_serializer.sv - one-at-a-time read/write arbiter in front of an AXI4-Lite subordinate
module bsg_axil_rw_serializer #(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    bsg_axil_rw_serializer_if.slave   s00_axil,
    bsg_axil_rw_serializer_if.master  m00_axil
);
    localparam int mask_width_lp = data_width_p >> 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        READ  = 3'd3,
        RRESP = 3'd4
    } state_e;

    state_e state_r;
    logic   last_wr_r;
    logic   aw_done_r;
    logic   w_done_r;

    logic   wr_req;
    logic   rd_req;
    logic   aw_hs;
    logic   w_hs;
    logic   b_hs;
    logic   ar_hs;
    logic   r_hs;

    // Channel gating: only the channels owned by the current state may handshake; payloads flow straight through
    always_comb begin
        m00_axil.awaddr  = addr_width_p'(s00_axil.awaddr);
        m00_axil.awprot  = s00_axil.awprot;
        m00_axil.wdata   = data_width_p'(s00_axil.wdata);
        m00_axil.wstrb   = mask_width_lp'(s00_axil.wstrb);
        m00_axil.araddr  = addr_width_p'(s00_axil.araddr);
        m00_axil.arprot  = s00_axil.arprot;
        s00_axil.bresp   = m00_axil.bresp;
        s00_axil.rdata   = m00_axil.rdata;
        s00_axil.rresp   = m00_axil.rresp;

        m00_axil.awvalid = 1'b0;
        s00_axil.awready = 1'b0;
        m00_axil.wvalid  = 1'b0;
        s00_axil.wready  = 1'b0;
        s00_axil.bvalid  = 1'b0;
        m00_axil.bready  = 1'b0;
        m00_axil.arvalid = 1'b0;
        s00_axil.arready = 1'b0;
        s00_axil.rvalid  = 1'b0;
        m00_axil.rready  = 1'b0;

        unique case (state_r)
            WRITE: begin
                // Once a channel has handshaken, mask it so the same beat is not forwarded twice
                m00_axil.awvalid = s00_axil.awvalid & ~aw_done_r;
                s00_axil.awready = m00_axil.awready & ~aw_done_r;
                m00_axil.wvalid  = s00_axil.wvalid & ~w_done_r;
                s00_axil.wready  = m00_axil.wready & ~w_done_r;
            end
            WRESP: begin
                s00_axil.bvalid  = m00_axil.bvalid;
                m00_axil.bready  = s00_axil.bready;
            end
            READ: begin
                m00_axil.arvalid = s00_axil.arvalid;
                s00_axil.arready = m00_axil.arready;
            end
            RRESP: begin
                s00_axil.rvalid  = m00_axil.rvalid;
                m00_axil.rready  = s00_axil.rready;
            end
            default: begin
            end
        endcase

        wr_req = s00_axil.awvalid | s00_axil.wvalid;
        rd_req = s00_axil.arvalid;
        aw_hs  = m00_axil.awvalid & m00_axil.awready;
        w_hs   = m00_axil.wvalid & m00_axil.wready;
        b_hs   = s00_axil.bvalid & s00_axil.bready;
        ar_hs  = m00_axil.arvalid & m00_axil.arready;
        r_hs   = s00_axil.rvalid & s00_axil.rready;
    end

    // Transaction sequencer: registered round-robin grant, then walk the owned channels to completion
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= IDLE;
            last_wr_r <= 1'b0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            unique case (state_r)
                IDLE: begin
                    if (wr_req && (!rd_req || !last_wr_r)) begin
                        state_r   <= WRITE;
                        last_wr_r <= 1'b1;
                    end else if (rd_req) begin
                        state_r   <= READ;
                        last_wr_r <= 1'b0;
                    end
                end
                WRITE: begin
                    if ((aw_done_r || aw_hs) && (w_done_r || w_hs)) begin
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        state_r   <= WRESP;
                    end else begin
                        if (aw_hs) aw_done_r <= 1'b1;
                        if (w_hs)  w_done_r  <= 1'b1;
                    end
                end
                WRESP: begin
                    if (b_hs) state_r <= IDLE;
                end
                READ: begin
                    if (ar_hs) state_r <= RRESP;
                end
                RRESP: begin
                    if (r_hs) state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bsg_axil_rw_serializer.sv
// tb/tb_bsg_axil_rw_serializer.sv - directed self-checking bench for bsg_axil_rw_serializer
module tb_bsg_axil_rw_serializer;
    logic clk_i = 1'b0;
    logic reset_i;
    int   errors = 0;
    int   checks = 0;

    always #5 clk_i = ~clk_i;

    bsg_axil_rw_serializer_if #(.addr_width_p(32), .data_width_p(32)) s00 ();
    bsg_axil_rw_serializer_if #(.addr_width_p(32), .data_width_p(32)) m00 ();

    bsg_axil_rw_serializer #(.addr_width_p(32), .data_width_p(32)) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .s00_axil (s00),
        .m00_axil (m00)
    );

    wire [9:0] hs_outs = {m00.awvalid, m00.wvalid, m00.arvalid, m00.bready, m00.rready,
                          s00.awready, s00.wready, s00.arready, s00.bvalid, s00.rvalid};

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        s00.awaddr = '0; s00.awprot = '0; s00.awvalid = 1'b0;
        s00.wdata = '0; s00.wstrb = '1; s00.wvalid = 1'b0;
        s00.bready = 1'b0;
        s00.araddr = '0; s00.arprot = '0; s00.arvalid = 1'b0;
        s00.rready = 1'b0;
        m00.awready = 1'b0; m00.wready = 1'b0;
        m00.bresp = '0; m00.bvalid = 1'b0;
        m00.arready = 1'b0;
        m00.rdata = '0; m00.rresp = '0; m00.rvalid = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (hs_outs !== 10'b0) begin
            errors++; $display("FAIL reset_outs got=%b exp=%b", hs_outs, 10'b0);
        end
    endtask

    task automatic test_write_basic();
        s00.awvalid = 1'b1; s00.awaddr = 32'h100;
        s00.wvalid = 1'b1; s00.wdata = 32'h55;
        m00.awready = 1'b1; m00.wready = 1'b1;
        #1;
        checks++;
        if (m00.awvalid !== 1'b0) begin
            errors++; $display("FAIL wr_idle_awvalid got=%b exp=0", m00.awvalid);
        end
        tick();
        checks++;
        if ({m00.awvalid, m00.wvalid, s00.awready, s00.wready} !== 4'b1111) begin
            errors++; $display("FAIL wr_fwd_valids got=%b exp=1111",
                               {m00.awvalid, m00.wvalid, s00.awready, s00.wready});
        end
        checks++;
        if (m00.awaddr !== 32'h100 || m00.wdata !== 32'h55) begin
            errors++; $display("FAIL wr_payload got=%h/%h exp=100/55", m00.awaddr, m00.wdata);
        end
        tick();
        s00.awvalid = 1'b0; s00.wvalid = 1'b0;
        m00.bvalid = 1'b1; m00.bresp = 2'b00; s00.bready = 1'b1;
        #1;
        checks++;
        if ({s00.bvalid, m00.bready} !== 2'b11 || s00.bresp !== 2'b00) begin
            errors++; $display("FAIL wr_bresp got=%b resp=%b exp=11 resp=00",
                               {s00.bvalid, m00.bready}, s00.bresp);
        end
        tick();
        checks++;
        if ({s00.bvalid, m00.bready} !== 2'b00) begin
            errors++; $display("FAIL wr_back_idle got=%b exp=00", {s00.bvalid, m00.bready});
        end
        clear_inputs();
    endtask

    task automatic test_w_before_aw();
        int w_beats;
        int b_beats;
        w_beats = 0;
        b_beats = 0;
        m00.awready = 1'b1; m00.wready = 1'b1;
        s00.wvalid = 1'b1; s00.wdata = 32'h77;
        s00.awaddr = 32'h180;
        tick();
        checks++;
        if ({m00.wvalid, m00.awvalid} !== 2'b10) begin
            errors++; $display("FAIL wfirst_fwd got=%b exp=10", {m00.wvalid, m00.awvalid});
        end
        for (int i = 0; i < 3; i++) begin
            if (m00.wvalid && m00.wready) w_beats++;
            if (i == 2) s00.awvalid = 1'b1;
            #1;
            tick();
        end
        checks++;
        if (w_beats !== 1) begin
            errors++; $display("FAIL wfirst_w_beats got=%0d exp=1", w_beats);
        end
        s00.awvalid = 1'b0; s00.wvalid = 1'b0;
        m00.bvalid = 1'b1; s00.bready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (s00.bvalid && s00.bready) b_beats++;
            tick();
        end
        checks++;
        if (b_beats !== 1) begin
            errors++; $display("FAIL wfirst_b_beats got=%0d exp=1", b_beats);
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        int n;
        logic [31:0] waddr;
        logic [31:0] raddr;
        do_reset();
        n = 0;
        waddr = 32'h1000;
        raddr = 32'h2000;
        s00.awvalid = 1'b1; s00.wvalid = 1'b1; s00.arvalid = 1'b1;
        s00.bready = 1'b1; s00.rready = 1'b1;
        m00.awready = 1'b1; m00.wready = 1'b1; m00.arready = 1'b1;
        m00.bvalid = 1'b1; m00.rvalid = 1'b1;
        for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
            s00.awaddr = waddr; s00.wdata = ~waddr; s00.araddr = raddr;
            m00.rdata = 32'hA000_0000 + 32'(cyc);
            #1;
            if (m00.arvalid && (m00.awvalid || m00.wvalid || m00.bready)) begin
                checks++; errors++;
                $display("FAIL rr_overlap got=ar_with_write exp=exclusive");
            end
            if (m00.awvalid && m00.awready) begin
                checks++;
                if ((n % 2) != 0 || m00.awaddr !== waddr || m00.wdata !== ~waddr) begin
                    errors++; $display("FAIL rr_write txn=%0d addr=%h exp_addr=%h exp_slot=even",
                                       n, m00.awaddr, waddr);
                end
                n++; waddr = waddr + 4;
            end
            if (m00.arvalid && m00.arready) begin
                checks++;
                if ((n % 2) != 1 || m00.araddr !== raddr) begin
                    errors++; $display("FAIL rr_read txn=%0d addr=%h exp_addr=%h exp_slot=odd",
                                       n, m00.araddr, raddr);
                end
                n++; raddr = raddr + 4;
            end
            if (s00.rvalid) begin
                checks++;
                if (s00.rdata !== 32'hA000_0000 + 32'(cyc)) begin
                    errors++; $display("FAIL rr_rdata got=%h exp=%h", s00.rdata, 32'hA000_0000 + 32'(cyc));
                end
            end
            tick();
        end
        checks++;
        if (n !== 8) begin
            errors++; $display("FAIL rr_count got=%0d exp=8", n);
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_aw_stall();
        do_reset();
        s00.awvalid = 1'b1; s00.awaddr = 32'h200;
        s00.wvalid = 1'b1; s00.wdata = 32'h1234;
        s00.arvalid = 1'b1; s00.araddr = 32'h300;
        m00.wready = 1'b1; m00.awready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (m00.awvalid !== 1'b1 || m00.awaddr !== 32'h200 || s00.arready !== 1'b0 || m00.arvalid !== 1'b0) begin
                errors++; $display("FAIL stall_hold cyc=%0d awv=%b addr=%h arrdy=%b exp=1/200/0",
                                   i, m00.awvalid, m00.awaddr, s00.arready);
            end
            tick();
            s00.wvalid = 1'b0;
            #1;
        end
        m00.awready = 1'b1;
        tick();
        s00.awvalid = 1'b0;
        m00.bvalid = 1'b1; s00.bready = 1'b1;
        #1;
        checks++;
        if (s00.arready !== 1'b0) begin
            errors++; $display("FAIL stall_arready_wresp got=%b exp=0", s00.arready);
        end
        tick();
        m00.bvalid = 1'b0;
        m00.arready = 1'b1;
        tick();
        checks++;
        if (m00.arvalid !== 1'b1 || m00.araddr !== 32'h300) begin
            errors++; $display("FAIL stall_read_after got=%b/%h exp=1/300", m00.arvalid, m00.araddr);
        end
        tick();
        s00.arvalid = 1'b0;
        m00.rvalid = 1'b1; s00.rready = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_in_rresp();
        do_reset();
        s00.arvalid = 1'b1; s00.araddr = 32'h40;
        m00.arready = 1'b1;
        tick();
        tick();
        s00.arvalid = 1'b0; s00.rready = 1'b1;
        #1;
        checks++;
        if (m00.rready !== 1'b1) begin
            errors++; $display("FAIL rst_rresp_rready got=%b exp=1", m00.rready);
        end
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        #1;
        checks++;
        if (hs_outs !== 10'b0) begin
            errors++; $display("FAIL rst_mid_outs got=%b exp=%b", hs_outs, 10'b0);
        end
        s00.arvalid = 1'b1; s00.araddr = 32'h44;
        tick();
        checks++;
        if (m00.arvalid !== 1'b1 || m00.araddr !== 32'h44) begin
            errors++; $display("FAIL rst_new_ar got=%b/%h exp=1/44", m00.arvalid, m00.araddr);
        end
        tick();
        s00.arvalid = 1'b0;
        m00.rvalid = 1'b1; m00.rdata = 32'hDEAD_BEEF; m00.rresp = 2'b10;
        #1;
        checks++;
        if (s00.rvalid !== 1'b1 || s00.rdata !== 32'hDEAD_BEEF || s00.rresp !== 2'b10) begin
            errors++; $display("FAIL rst_new_r got=%b/%h/%b exp=1/deadbeef/10",
                               s00.rvalid, s00.rdata, s00.rresp);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_stray_resp();
        do_reset();
        m00.bvalid = 1'b1; m00.rvalid = 1'b1;
        s00.bready = 1'b1; s00.rready = 1'b1;
        #1;
        checks++;
        if ({m00.bready, s00.bvalid, m00.rready, s00.rvalid} !== 4'b0000) begin
            errors++; $display("FAIL stray_idle got=%b exp=0000",
                               {m00.bready, s00.bvalid, m00.rready, s00.rvalid});
        end
        tick();
        m00.rvalid = 1'b0;
        s00.arvalid = 1'b1; s00.araddr = 32'h80;
        tick();
        checks++;
        if ({m00.arvalid, m00.bready, s00.bvalid} !== 3'b100) begin
            errors++; $display("FAIL stray_read got=%b exp=100", {m00.arvalid, m00.bready, s00.bvalid});
        end
        tick();
        checks++;
        if ({m00.arvalid, m00.bready, s00.bvalid} !== 3'b100) begin
            errors++; $display("FAIL stray_read_hold got=%b exp=100", {m00.arvalid, m00.bready, s00.bvalid});
        end
        m00.arready = 1'b1;
        tick();
        s00.arvalid = 1'b0;
        m00.rvalid = 1'b1;
        tick();
        clear_inputs();
    endtask

    initial begin
        reset_i = 1'b1;
        clear_inputs();
        test_reset();
        test_write_basic();
        test_w_before_aw();
        test_back_to_back();
        test_aw_stall();
        test_reset_in_rresp();
        test_stray_resp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
